// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the muxn_rr_stream slice.
//   mode_e  - arbitration mode encoding (MODE_FIXED = 0, MODE_RR = 1)
//   clog2   - ceiling log2, used to size select/index fields
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_rr_stream_if.sv
// muxn_rr_stream_if: bundles the stream-side signals of muxn_rr_stream.
//   master - the side feeding channels and consuming the output stream
//   slave  - the mux itself
// Signals: in_data/in_valid/in_ready (N_CH channels), mode/sel (control),
//          out_data/out_ch/out_valid/out_ready (output stream).
interface muxn_rr_stream_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned SW = mux_pkg::clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SW-1:0]         sel;
    logic [WIDTH-1:0]      out_data;
    logic [SW-1:0]         out_ch;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority search.
//   req     - per-channel request
//   ptr     - last granted channel; search starts at ptr+1
//   gnt_idx - first requesting channel found (0 when none)
//   gnt_any - at least one request present
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned SW  = clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int unsigned idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/muxn_rr_stream.sv
// muxn_rr_stream: N-channel stream mux with one registered output beat.
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/in_valid    - channel i data at [i*WIDTH +: WIDTH], per-channel valid
//   in_ready            - combinational per-channel ready (at most one high)
//   mode, sel           - 0: always serve channel sel; 1: round-robin
//   out_data/out_ch     - registered data and its source channel
//   out_valid/out_ready - output handshake
module muxn_rr_stream
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SW   = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SW-1:0]         out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    mode_e            cur_mode;
    logic             load;
    logic             xfer;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [SW-1:0]    pick_idx;
    logic [WIDTH-1:0] pick_data;
    logic [N_CH-1:0]  ready_vec;

    assign cur_mode = mode_e'(mode);
    assign load     = !out_valid || out_ready;

    rr_pick #(.N_CH(N_CH)) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Fixed mode raises ready on sel from load alone, so the served
    // channel's ready never depends on its own valid.
    always_comb begin
        ready_vec = '0;
        pick_idx  = (cur_mode == MODE_RR) ? gnt_idx : sel;
        if (rst_n && load) begin
            if (cur_mode == MODE_FIXED) begin
                ready_vec[sel] = 1'b1;
            end else if (gnt_any) begin
                ready_vec[gnt_idx] = 1'b1;
            end
        end
        pick_data = in_data[pick_idx*WIDTH +: WIDTH];
    end

    assign in_ready = ready_vec;
    assign xfer     = |(in_valid & ready_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(N_CH - 1);
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= pick_data;
                    out_ch   <= pick_idx;
                end
            end
            if (xfer && cur_mode == MODE_RR) begin
                ptr <= gnt_idx;
            end
        end
    end

endmodule
